// File: rtl/mc_control_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences register enables
// and datapath mux selects one instruction at a time, stalling on mem_ready.
module mc_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t state_q, state_d;
  logic   mem_rdy;
  logic   pc_update_c, branch_c;
  logic   ir_write_c, mem_write_c, reg_write_c, illegal_op_c, instr_done_c;

  assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = S_FETCH;
    pc_update_c  = 1'b0;
    branch_c     = 1'b0;
    ir_write_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    illegal_op_c = 1'b0;
    instr_done_c = 1'b0;
    adr_src      = 1'b0;
    result_src   = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        ir_write_c  = mem_rdy;
        pc_update_c = mem_rdy;
        state_d     = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // OldPC + ImmExt precomputes the branch target into ALUOut
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        unique case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BEQ:            state_d = S_BEQ;
          default: begin
            illegal_op_c = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src   = 2'b01;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        // strobe stays high through stall cycles; memory accepts on mem_ready
        adr_src      = 1'b1;
        mem_write_c  = 1'b1;
        instr_done_c = mem_rdy;
        state_d      = mem_rdy ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        pc_update_c = 1'b1;
        state_d     = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a    = 2'b10;
        alu_op       = 2'b01;
        branch_c     = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are masked during reset; the mux selects already read as FETCH.
  assign pc_write   = (pc_update_c | (branch_c & zero)) & ~reset;
  assign ir_write   = ir_write_c   & ~reset;
  assign mem_write  = mem_write_c  & ~reset;
  assign reg_write  = reg_write_c  & ~reset;
  assign illegal_op = illegal_op_c & ~reset;
  assign instr_done = instr_done_c & ~reset;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected state, enables and
// mux selects are queued with each stimulus and compared against the DUT.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op, instr_done;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] st;
    logic [5:0] en;   // {pc_write, ir_write, mem_write, reg_write, instr_done, illegal_op}
  } exp_t;
  exp_t sb_q[$];

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b0110111;

  mc_control_fsm #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .illegal_op(illegal_op), .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected mux selects {adr_src, result_src, alu_src_a, alu_src_b, alu_op} per state
  function automatic logic [8:0] sel_of(input logic [3:0] s);
    case (s)
      4'd0:    return 9'b0_10_00_10_00;
      4'd1:    return 9'b0_00_01_01_00;
      4'd2:    return 9'b0_00_10_01_00;
      4'd3:    return 9'b1_00_00_00_00;
      4'd4:    return 9'b0_01_00_00_00;
      4'd5:    return 9'b1_00_00_00_00;
      4'd6:    return 9'b0_00_10_00_10;
      4'd8:    return 9'b0_00_10_01_10;
      4'd9:    return 9'b0_00_01_10_00;
      4'd10:   return 9'b0_00_10_00_01;
      default: return 9'b0_00_00_00_00;
    endcase
  endfunction

  function automatic logic [5:0] en_now();
    return {pc_write, ir_write, mem_write, reg_write, instr_done, illegal_op};
  endfunction

  // Called at posedge+1: drive inputs, queue expectation, compare at posedge+3,
  // then advance to the next posedge+1.
  task automatic step(input logic [6:0] o, input logic z, input logic mr,
                      input logic [3:0] est, input logic [5:0] een);
    exp_t e;
    op = o; zero = z; mem_ready = mr;
    e.st = est; e.en = een;
    sb_q.push_back(e);
    #2;
    e = sb_q.pop_front();
    $display("cycle t=%0t op=%b zero=%b mr=%b state=%0d en=%b sel=%b",
             $time, o, z, mr, state, en_now(), {adr_src, result_src, alu_src_a, alu_src_b, alu_op});
    check("state", {12'd0, state}, {12'd0, e.st});
    check("enables", {10'd0, en_now()}, {10'd0, e.en});
    check("selects", {7'd0, adr_src, result_src, alu_src_a, alu_src_b, alu_op}, {7'd0, sel_of(e.st)});
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; op = RT; zero = 1'b0; mem_ready = 1'b1;
    #1;
    check("rst_state", {12'd0, state}, 16'd0);
    check("rst_en", {10'd0, en_now()}, 16'd0);
    check("rst_sel", {7'd0, adr_src, result_src, alu_src_a, alu_src_b, alu_op}, {7'd0, sel_of(4'd0)});
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // R-type interrupted by reset in EXECR
    step(RT, 1'b1, 1'b1, 4'd0, 6'b110000);
    step(RT, 1'b1, 1'b1, 4'd1, 6'b000000);
    #2;
    check("execr_state", {12'd0, state}, 16'd6);
    reset = 1'b1;
    #1;
    check("async_rst_state", {12'd0, state}, 16'd0);
    check("async_rst_en", {10'd0, en_now()}, 16'd0);
    #14;
    check("held_rst_state", {12'd0, state}, 16'd0);
    check("held_rst_en", {10'd0, en_now()}, 16'd0);
    reset = 1'b0;
    #1;
    check("post_rst_en", {10'd0, en_now()}, {10'd0, 6'b110000});
    @(posedge clk); #1;
    check("post_rst_state", {12'd0, state}, 16'd1);
    step(RT, 1'b1, 1'b1, 4'd1, 6'b000000);
    step(RT, 1'b1, 1'b1, 4'd6, 6'b000000);
    step(RT, 1'b1, 1'b1, 4'd7, 6'b000110);

    // lw with one stall in FETCH and one in MEMREAD
    step(LW, 1'b0, 1'b0, 4'd0, 6'b000000);
    step(LW, 1'b0, 1'b1, 4'd0, 6'b110000);
    step(LW, 1'b0, 1'b1, 4'd1, 6'b000000);
    step(LW, 1'b0, 1'b1, 4'd2, 6'b000000);
    step(LW, 1'b0, 1'b0, 4'd3, 6'b000000);
    step(LW, 1'b0, 1'b1, 4'd3, 6'b000000);
    step(LW, 1'b0, 1'b1, 4'd4, 6'b000110);

    // lw without stalls
    step(LW, 1'b0, 1'b1, 4'd0, 6'b110000);
    step(LW, 1'b0, 1'b1, 4'd1, 6'b000000);
    step(LW, 1'b0, 1'b1, 4'd2, 6'b000000);
    step(LW, 1'b0, 1'b1, 4'd3, 6'b000000);
    step(LW, 1'b0, 1'b1, 4'd4, 6'b000110);

    // sw with three stall cycles in MEMWRITE
    step(SW, 1'b0, 1'b1, 4'd0, 6'b110000);
    step(SW, 1'b0, 1'b1, 4'd1, 6'b000000);
    step(SW, 1'b0, 1'b1, 4'd2, 6'b000000);
    for (int i = 0; i < 3; i++) step(SW, 1'b0, 1'b0, 4'd5, 6'b001000);
    step(SW, 1'b0, 1'b1, 4'd5, 6'b001010);

    // beq taken then not taken
    step(BQ, 1'b1, 1'b1, 4'd0, 6'b110000);
    step(BQ, 1'b1, 1'b1, 4'd1, 6'b000000);
    step(BQ, 1'b1, 1'b1, 4'd10, 6'b100010);
    step(BQ, 1'b0, 1'b1, 4'd0, 6'b110000);
    step(BQ, 1'b0, 1'b1, 4'd1, 6'b000000);
    step(BQ, 1'b0, 1'b1, 4'd10, 6'b000010);

    // jal
    step(JL, 1'b0, 1'b1, 4'd0, 6'b110000);
    step(JL, 1'b0, 1'b1, 4'd1, 6'b000000);
    step(JL, 1'b0, 1'b1, 4'd9, 6'b100000);
    step(JL, 1'b0, 1'b1, 4'd7, 6'b000110);

    // I-type
    step(IT, 1'b0, 1'b1, 4'd0, 6'b110000);
    step(IT, 1'b0, 1'b1, 4'd1, 6'b000000);
    step(IT, 1'b0, 1'b1, 4'd8, 6'b000000);
    step(IT, 1'b0, 1'b1, 4'd7, 6'b000110);

    // unsupported opcode
    step(BAD, 1'b0, 1'b1, 4'd0, 6'b110000);
    step(BAD, 1'b0, 1'b1, 4'd1, 6'b000001);
    step(BAD, 1'b0, 1'b1, 4'd0, 6'b110000);
    step(BAD, 1'b0, 1'b1, 4'd1, 6'b000001);
    step(RT, 1'b0, 1'b1, 4'd0, 6'b110000);

    check("sb_empty", {15'd0, sb_q.size() == 0}, 16'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Main control state machine for the multicycle RV32I core. It sequences the architectural and non-architectural flopr/enable registers (PC, IR, OldPC, Data, ALUOut) and the datapath muxes, one instruction at a time. It stalls on a memory ready handshake and flags unsupported opcodes. The ALU decoder stays outside this block and consumes alu_op.

Parameters:
MEM_HANDSHAKE, 1, 1 = FETCH/MEMREAD/MEMWRITE hold until mem_ready; 0 = mem_ready ignored (treated as 1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; forces state to FETCH
op  input  7  instr[6:0] from IR
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  PC register enable = pc_update | (branch & zero)
adr_src  output  1  0 = PC, 1 = ALUOut to memory address
mem_write  output  1  memory write strobe
ir_write  output  1  IR/OldPC enable
result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1 reg
alu_src_b  output  2  00 rs2 reg, 01 ImmExt, 10 constant 4
alu_op  output  2  00 add, 01 sub/compare, 10 funct-decoded
reg_write  output  1  register file write enable
illegal_op  output  1  one-cycle pulse, unsupported opcode seen in DECODE
instr_done  output  1  one-cycle pulse in the final state of each instruction
state  output  4  current state encoding (debug)

Behaviour:
- Moore FSM: state is the only register; outputs are decoded from state, except pc_write (needs zero) and the mem_ready gating.
- Encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10; 11-15 unreachable and return to FETCH.
- Reset: state = FETCH immediately, mid-instruction included. While reset = 1, pc_write, ir_write, mem_write, reg_write, illegal_op and instr_done are forced to 0. Mux selects show their FETCH values.
- Default per state: every output not listed = 0.
- FETCH: adr_src 0, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10.
  - ir_write = pc_update = mem_ready.
  - Goes to DECODE when mem_ready = 1, otherwise holds.
- DECODE: alu_src_a 01, alu_src_b 01, alu_op 00 (branch target into ALUOut).
  - op 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BEQ.
  - Any other op -> FETCH, with illegal_op = 1 this cycle.
- MEMADR: alu_src_a 10, alu_src_b 01, alu_op 00. Goes to MEMREAD if op = 0000011, else MEMWRITE.
- MEMREAD: adr_src 1, result_src 00. Goes to MEMWB when mem_ready = 1, otherwise holds.
- MEMWB: result_src 01, reg_write 1, instr_done 1. Goes to FETCH.
- MEMWRITE: adr_src 1, result_src 00.
  - mem_write = 1 in every cycle the state is held, including stall cycles.
  - instr_done = mem_ready; goes to FETCH when mem_ready = 1.
- EXECR: alu_src_a 10, alu_src_b 00, alu_op 10. Goes to ALUWB.
- EXECI: alu_src_a 10, alu_src_b 01, alu_op 10. Goes to ALUWB.
- ALUWB: result_src 00, reg_write 1, instr_done 1. Goes to FETCH.
- JAL: alu_src_a 01, alu_src_b 10, alu_op 00, result_src 00, pc_update 1. Goes to ALUWB.
- BEQ: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00, branch 1, instr_done 1. Goes to FETCH.
  - pc_write = zero.
- Cycle counts with mem_ready = 1: lw 5, sw 4, R/I-type 4, jal 4, beq 3.
- Each cycle of mem_ready = 0 in FETCH/MEMREAD/MEMWRITE adds exactly one cycle.
- MEM_HANDSHAKE = 0: mem_ready is internally tied to 1.
- At most one of reg_write, mem_write, ir_write is high in any cycle.

Test Plan:
- Reset asserted for 15 ns mid-EXECR, released -> state = 0 asynchronously and all enables 0 during reset. First posedge after release with mem_ready = 1: ir_write = pc_write = 1, state becomes 1.
- op = 0000011, mem_ready = 1 always -> states 0,1,2,3,4,0. reg_write and instr_done high only in state 4, result_src = 01 there.
- op = 0100011, mem_ready low for 3 cycles in MEMWRITE -> state 5 held 4 cycles with mem_write = 1 each cycle, instr_done only in the last, then state 0.
- op = 1100011 with zero = 1, then repeated with zero = 0 -> states 0,1,10. pc_write = 1 in state 10 for the first run and 0 for the second. alu_op = 01.
- op = 1101111 -> states 0,1,9,7. pc_write = 1 in state 9, reg_write = 1 in state 7, result_src = 00.
- op = 0110111 (unsupported) -> DECODE pulses illegal_op = 1 for one cycle, then FETCH; no reg_write or mem_write ever asserted.
